uart_rx: RTL

//  UART receiver, 8N1 by default; counterpart of the uart_tx transmitter on the same link.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the UART link: receiver FSM state encoding,
//   default line parameters and the clocks-per-bit helper used by both ends.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_BIT_RATE = 9600;
  localparam int unsigned DEFAULT_CLK_HZ   = 12_000_000;

  // Clock cycles per line bit; integer division, caller guarantees >= 8.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer for the asynchronous serial input. Both flops are
//   preset to 1 in reset so the receiver sees an idle line, not a start bit.
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (presets to 1)
//   d_i    in  asynchronous serial input
//   q_o    out synchronized serial input
// -----------------------------------------------------------------------------
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make meta_q -> sync_q a real two-stage
      // pipeline; blocking ones would collapse it into a single flop.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver (8N1 by default). Samples the synchronized line at mid-bit
//   and reports each frame as a one-cycle valid strobe, a frame-error strobe,
//   or a frame-error plus break strobe.
// Ports
//   CLK                in  system clock, CLK_HZ
//   resetn             in  asynchronous active-low reset
//   uart_rxd           in  serial input, idle high, asynchronous to CLK
//   uart_rx_en         in  1 = accept new start bits
//   uart_rx_valid      out one-cycle pulse, uart_rx_data holds a new frame
//   uart_rx_data       out last good payload, held until the next good frame
//   uart_rx_frame_err  out one-cycle pulse, stop bit sampled low
//   uart_rx_break      out one-cycle pulse, all data bits and stop bit low
//   uart_rx_busy       out 1 while a frame is being received or line held low
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BIT_RATE     = DEFAULT_BIT_RATE,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_busy
);

  localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CYC_W = $clog2(CPB);
  localparam int unsigned IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(CPB / 2 - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

  logic rxd_s;

  uart_sync u_sync (
    .clk   (CLK),
    .rst_n (resetn),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  state_e                  state_q;
  logic [CYC_W-1:0]        cyc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic [PAYLOAD_BITS-1:0] shift_d;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    valid_q;
  logic                    err_q;
  logic                    brk_q;

  // Line order is LSB first: each new bit enters at the MSB and the earlier
  // bits move down, so after the last bit the word is in natural order.
  always_comb begin
    // NOTE: assigning a default before the partial update keeps this purely
    // combinational; a path that leaves shift_d unassigned would infer a latch.
    shift_d                   = shift_q >> 1;
    shift_d[PAYLOAD_BITS-1]   = rxd_s;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless set below.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      brk_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (uart_rx_en && !rxd_s) begin
            state_q <= START;
            cyc_q   <= '0;
          end
        end

        // Re-check the start bit at its midpoint; a high line means a glitch.
        START: begin
          if (cyc_q == CYC_HALF) begin
            cyc_q   <= '0;
            idx_q   <= '0;
            state_q <= rxd_s ? IDLE : DATA;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        // Counting from mid start bit, each full bit period lands mid-bit.
        DATA: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q   <= '0;
            shift_q <= shift_d;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        // Leaving at mid stop bit gives half a bit of slack before the next
        // start edge, so back-to-back single-stop frames are not missed.
        STOP: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (rxd_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              err_q   <= 1'b1;
              brk_q   <= (shift_q == '0);
              state_q <= WAIT_HIGH;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        // A held-low line (break) must not be taken as a stream of start bits.
        WAIT_HIGH: begin
          if (rxd_s) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_frame_err = err_q;
  assign uart_rx_break     = brk_q;
  assign uart_rx_busy      = (state_q != IDLE);

endmodule
